// File: rtl/r5p_soc_uart_rx.sv
// UART 8N1 receiver with programmable bit period, small receive FIFO and a TCB
// responder for data/status/baud/irq registers.
module r5p_soc_uart_rx #(
  parameter logic [15:0] CFG_BDR  = 16'd174,
  parameter int unsigned FIFO_DEP = 4
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        tcb_vld,
  output logic        tcb_rdy,
  input  logic        tcb_wen,
  input  logic [3:0]  tcb_adr,
  input  logic [3:0]  tcb_ben,
  input  logic [31:0] tcb_wdt,
  output logic [31:0] tcb_rdt,
  output logic        tcb_err,
  input  logic        uart_rxd,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEP);

  typedef enum logic [2:0] {S_IDLE, S_STRT, S_DATA, S_STOP, S_WAIT} state_t;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_idx;
  logic [7:0]  r_sh;
  logic        r_rx0, r_rxs;
  logic [15:0] r_baud;
  logic        r_ien, r_ovr, r_fer;
  logic [AW:0] r_wp, r_rp;
  logic [7:0]  r_mem [FIFO_DEP];
  logic [31:0] r_rdt;
  logic        r_err;

  logic [AW:0] w_cnt;
  logic [31:0] w_cnt32;
  logic [3:0]  w_cnt_sat;
  logic        w_ne, w_full;
  logic        w_trn, w_algn, w_rd, w_wr;
  logic        w_sel_data, w_sel_stat, w_sel_baud, w_sel_irq;
  logic        w_pop, w_push_ok, w_push, w_ovr_set, w_fer_set;
  logic        w_clr_ovr, w_clr_fer;
  logic [15:0] w_bdr_new;
  logic [31:0] w_rdt;
  logic        w_unused;

  assign tcb_rdy = 1'b1;
  assign tcb_rdt = r_rdt;
  assign tcb_err = r_err;
  assign irq     = r_ien & w_ne;

  assign w_cnt     = r_wp - r_rp;
  assign w_cnt32   = 32'(w_cnt);
  assign w_cnt_sat = (w_cnt32 > 32'd15) ? 4'd15 : w_cnt32[3:0];
  assign w_ne      = (w_cnt != '0);
  assign w_full    = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);

  assign w_trn      = tcb_vld & tcb_rdy;
  assign w_algn     = (tcb_adr[1:0] == 2'b00);
  assign w_rd       = w_trn & w_algn & ~tcb_wen;
  assign w_wr       = w_trn & w_algn &  tcb_wen;
  assign w_sel_data = (tcb_adr[3:2] == 2'd0);
  assign w_sel_stat = (tcb_adr[3:2] == 2'd1);
  assign w_sel_baud = (tcb_adr[3:2] == 2'd2);
  assign w_sel_irq  = (tcb_adr[3:2] == 2'd3);

  // A full FIFO can still accept the byte when the same cycle pops an entry.
  assign w_pop     = w_rd & w_sel_data & w_ne;
  assign w_push_ok = (r_state == S_STOP) && (r_cnt == 16'd0) &&  r_rxs;
  assign w_fer_set = (r_state == S_STOP) && (r_cnt == 16'd0) && !r_rxs;
  assign w_push    = w_push_ok & (~w_full | w_pop);
  assign w_ovr_set = w_push_ok & w_full & ~w_pop;

  assign w_clr_ovr = w_wr & w_sel_stat & tcb_ben[0] & tcb_wdt[2];
  assign w_clr_fer = w_wr & w_sel_stat & tcb_ben[0] & tcb_wdt[3];
  assign w_bdr_new = {tcb_ben[1] ? tcb_wdt[15:8] : r_baud[15:8],
                      tcb_ben[0] ? tcb_wdt[7:0]  : r_baud[7:0]};

  assign w_unused = &{1'b0, tcb_wdt[31:16], tcb_ben[3:2]};

  always_comb begin
    w_rdt = '0;
    case (tcb_adr[3:2])
      2'd0: if (w_ne) w_rdt = {23'd0, 1'b1, r_mem[r_rp[AW-1:0]]};
      2'd1: w_rdt = {24'd0, w_cnt_sat, r_fer, r_ovr, w_full, w_ne};
      2'd2: w_rdt = {16'd0, r_baud};
      default: w_rdt = {31'd0, r_ien};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx0 <= 1'b1;
      r_rxs <= 1'b1;
    end else begin
      r_rx0 <= uart_rxd;
      r_rxs <= r_rx0;
    end
  end

  // Counter reloads read BAUD live, so a mid-frame write applies at the next reload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_sh    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (!r_rxs) begin
          r_cnt   <= {1'b0, r_baud[15:1]} - 16'd1;
          r_state <= S_STRT;
        end
        S_STRT: if (r_cnt == 16'd0) begin
          if (!r_rxs) begin
            r_cnt   <= r_baud - 16'd1;
            r_idx   <= '0;
            r_state <= S_DATA;
          end else begin
            r_state <= S_IDLE;
          end
        end else r_cnt <= r_cnt - 16'd1;
        S_DATA: if (r_cnt == 16'd0) begin
          r_sh  <= {r_rxs, r_sh[7:1]};
          r_cnt <= r_baud - 16'd1;
          r_idx <= r_idx + 3'd1;
          if (r_idx == 3'd7) r_state <= S_STOP;
        end else r_cnt <= r_cnt - 16'd1;
        S_STOP: if (r_cnt == 16'd0) begin
          r_state <= r_rxs ? S_IDLE : S_WAIT;
        end else r_cnt <= r_cnt - 16'd1;
        S_WAIT: if (r_rxs) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= r_sh;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_ovr  <= 1'b0;
      r_fer  <= 1'b0;
      r_baud <= CFG_BDR;
      r_ien  <= 1'b0;
      r_rdt  <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      r_ovr <= (r_ovr & ~w_clr_ovr) | w_ovr_set;
      r_fer <= (r_fer & ~w_clr_fer) | w_fer_set;
      if (w_wr & w_sel_baud) r_baud <= (w_bdr_new < 16'd4) ? 16'd4 : w_bdr_new;
      if (w_wr & w_sel_irq & tcb_ben[0]) r_ien <= tcb_wdt[0];
      r_err <= w_trn & ~w_algn;
      r_rdt <= w_rd ? w_rdt : 32'd0;
    end
  end

endmodule

// File: tb/tb_r5p_soc_uart_rx.sv
// Randomized self-checking bench for r5p_soc_uart_rx against a queue-based FIFO model.
module tb_r5p_soc_uart_rx;
  localparam int DEP = 4;

  logic        clk = 1'b0, rst = 1'b1;
  logic        tcb_vld = 1'b0, tcb_wen = 1'b0;
  logic [3:0]  tcb_adr = '0, tcb_ben = '0;
  logic [31:0] tcb_wdt = '0;
  logic        uart_rxd = 1'b1;
  wire         tcb_rdy, tcb_err, irq;
  wire  [31:0] tcb_rdt;

  int errs = 0, checks = 0;
  byte unsigned q[$];
  bit m_ovr = 0, m_fer = 0;

  r5p_soc_uart_rx #(.CFG_BDR(16'd174), .FIFO_DEP(DEP)) dut (
    .clk(clk), .rst(rst), .tcb_vld(tcb_vld), .tcb_rdy(tcb_rdy), .tcb_wen(tcb_wen),
    .tcb_adr(tcb_adr), .tcb_ben(tcb_ben), .tcb_wdt(tcb_wdt), .tcb_rdt(tcb_rdt),
    .tcb_err(tcb_err), .uart_rxd(uart_rxd), .irq(irq));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errs);
    $fatal(1);
  end

  function automatic void m_rx(input byte unsigned b);
    if (q.size() < DEP) q.push_back(b); else m_ovr = 1;
  endfunction

  function automatic logic [31:0] m_status();
    int c = q.size();
    logic [3:0] cs = 4'((c > 15) ? 15 : c);
    return {24'd0, cs, m_fer, m_ovr, (c == DEP), (c != 0)};
  endfunction

  function automatic logic [31:0] m_data();
    if (q.size() == 0) return 32'd0;
    return {23'd0, 1'b1, q.pop_front()};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    tcb_vld = 1; tcb_wen = 1; tcb_adr = a; tcb_wdt = d; tcb_ben = be;
    tick(1);
    tcb_vld = 0; tcb_wen = 0;
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [31:0] d, output logic e);
    tcb_vld = 1; tcb_wen = 0; tcb_adr = a;
    tick(1);
    tcb_vld = 0;
    d = tcb_rdt; e = tcb_err;
  endtask

  // Drives one frame; the line is left at the stop-bit level.
  task automatic send(input logic [7:0] b, input int n, input logic stp);
    uart_rxd = 0; tick(n);
    for (int i = 0; i < 8; i++) begin uart_rxd = b[i]; tick(n); end
    uart_rxd = stp; tick(n);
  endtask

  task automatic test_reset();
    logic [31:0] d; logic e;
    checks++; if (tcb_rdy !== 1'b1) begin errs++; $display("FAIL reset_rdy: got %b expected 1", tcb_rdy); end
    checks++; if (tcb_rdt !== 32'd0) begin errs++; $display("FAIL reset_rdt: got %h expected 0", tcb_rdt); end
    checks++; if (tcb_err !== 1'b0) begin errs++; $display("FAIL reset_err: got %b expected 0", tcb_err); end
    checks++; if (irq !== 1'b0) begin errs++; $display("FAIL reset_irq: got %b expected 0", irq); end
    rst = 0; tick(2);
    bus_rd(4'h8, d, e);
    checks++; if (d !== 32'd174) begin errs++; $display("FAIL reset_baud: got %h expected %h", d, 32'd174); end
    bus_rd(4'h4, d, e);
    checks++; if (d !== m_status()) begin errs++; $display("FAIL reset_status: got %h expected %h", d, m_status()); end
    bus_rd(4'hC, d, e);
    checks++; if (d !== 32'd0) begin errs++; $display("FAIL reset_irqen: got %h expected 0", d); end
  endtask

  task automatic test_basic();
    logic [31:0] d, x; logic e;
    bus_wr(4'h8, 32'd8, 4'hF);
    send(8'hA5, 8, 1); m_rx(8'hA5);
    bus_rd(4'h4, d, e); x = m_status();
    checks++; if (d !== x) begin errs++; $display("FAIL basic_status: got %h expected %h", d, x); end
    checks++; if (irq !== 1'b0) begin errs++; $display("FAIL basic_irq: got %b expected 0", irq); end
    bus_rd(4'h0, d, e); x = m_data();
    checks++; if (d !== x) begin errs++; $display("FAIL basic_data: got %h expected %h", d, x); end
    bus_rd(4'h4, d, e); x = m_status();
    checks++; if (d !== x) begin errs++; $display("FAIL basic_status_empty: got %h expected %h", d, x); end
  endtask

  task automatic test_baud_reg();
    logic [31:0] d, v; logic e;
    v = $urandom_range(0, 3);
    bus_wr(4'h8, v, 4'hF);
    bus_rd(4'h8, d, e);
    checks++; if (d !== 32'd4) begin errs++; $display("FAIL baud_clamp: wrote %0d got %h expected 4", v, d); end
    v = $urandom_range(16'h0100, 16'hFFFF);
    bus_wr(4'h8, v, 4'hF);
    bus_wr(4'h8, 32'h0000_0012, 4'b0001);
    bus_rd(4'h8, d, e);
    checks++; if (d !== ((v & 32'hFF00) | 32'h12)) begin errs++; $display("FAIL baud_ben: got %h expected %h", d, (v & 32'hFF00) | 32'h12); end
    bus_wr(4'h8, 32'd8, 4'hF);
  endtask

  task automatic test_irq_overrun();
    logic [31:0] d, x; logic e;
    byte unsigned b[5] = '{8'h3C, 8'h00, 8'hFF, 8'h81, 8'h55};
    bus_wr(4'hC, 32'd1, 4'hF);
    fork
      for (int k = 0; k < 5; k++) send(b[k], 8, 1);
      begin
        tick(2 + 4 + 72);
        checks++; if (irq !== 1'b0) begin errs++; $display("FAIL irq_before_stop: got %b expected 0", irq); end
        tick(1);
        checks++; if (irq !== 1'b1) begin errs++; $display("FAIL irq_after_stop: got %b expected 1", irq); end
      end
    join
    for (int k = 0; k < 5; k++) m_rx(b[k]);
    bus_rd(4'h4, d, e); x = m_status();
    checks++; if (d !== x) begin errs++; $display("FAIL ovr_status: got %h expected %h", d, x); end
    for (int k = 0; k < 4; k++) begin
      bus_rd(4'h0, d, e); x = m_data();
      checks++; if (d !== x) begin errs++; $display("FAIL ovr_data%0d: got %h expected %h", k, d, x); end
      checks++; if (irq !== (q.size() != 0)) begin errs++; $display("FAIL ovr_irq%0d: got %b expected %b", k, irq, q.size() != 0); end
    end
    bus_wr(4'h4, 32'h4, 4'h1); m_ovr = 0;
    bus_rd(4'h4, d, e); x = m_status();
    checks++; if (d !== x) begin errs++; $display("FAIL ovr_clear: got %h expected %h", d, x); end
    bus_wr(4'hC, 32'd0, 4'hF);
  endtask

  task automatic test_framing();
    logic [31:0] d, x; logic e;
    send(8'h12, 8, 0);
    tick(24);
    uart_rxd = 1; tick(16);
    m_fer = 1;
    send(8'h34, 8, 1); m_rx(8'h34);
    bus_rd(4'h4, d, e); x = m_status();
    checks++; if (d !== x) begin errs++; $display("FAIL fer_status: got %h expected %h", d, x); end
    bus_rd(4'h0, d, e); x = m_data();
    checks++; if (d !== x) begin errs++; $display("FAIL fer_data: got %h expected %h", d, x); end
    bus_wr(4'h4, 32'h8, 4'h1); m_fer = 0;
    bus_rd(4'h4, d, e); x = m_status();
    checks++; if (d !== x) begin errs++; $display("FAIL fer_clear: got %h expected %h", d, x); end
  endtask

  task automatic test_glitch();
    logic [31:0] d, x; logic e;
    bus_wr(4'h8, 32'd16, 4'hF);
    uart_rxd = 0; tick(2); uart_rxd = 1; tick(48);
    bus_rd(4'h4, d, e); x = m_status();
    checks++; if (d !== x) begin errs++; $display("FAIL glitch_status: got %h expected %h", d, x); end
    send(8'h5A, 16, 1); m_rx(8'h5A);
    bus_rd(4'h0, d, e); x = m_data();
    checks++; if (d !== x) begin errs++; $display("FAIL glitch_data: got %h expected %h", d, x); end
    bus_wr(4'h8, 32'd8, 4'hF);
  endtask

  task automatic test_same_cycle();
    logic [31:0] d, x; logic e;
    byte unsigned b5;
    for (int k = 0; k < 4; k++) begin
      byte unsigned bb = 8'($urandom);
      send(bb, 8, 1); m_rx(bb);
    end
    b5 = 8'($urandom);
    fork
      send(b5, 8, 1);
      begin
        tick(2 + 4 + 72);
        tcb_vld = 1; tcb_wen = 0; tcb_adr = 4'h0;
        tick(1);
        tcb_vld = 0;
        d = tcb_rdt;
      end
    join
    x = m_data(); m_rx(b5);
    checks++; if (d !== x) begin errs++; $display("FAIL same_cycle_data: got %h expected %h", d, x); end
    bus_rd(4'h4, d, e); x = m_status();
    checks++; if (d !== x) begin errs++; $display("FAIL same_cycle_status: got %h expected %h", d, x); end
    bus_rd(4'h2, d, e);
    checks++; if (e !== 1'b1) begin errs++; $display("FAIL misalign_err: got %b expected 1", e); end
    checks++; if (d !== 32'd0) begin errs++; $display("FAIL misalign_rdt: got %h expected 0", d); end
    bus_rd(4'h4, d, e); x = m_status();
    checks++; if (d !== x) begin errs++; $display("FAIL misalign_nopop: got %h expected %h", d, x); end
    for (int k = 0; k < 4; k++) begin
      bus_rd(4'h0, d, e); x = m_data();
      checks++; if (d !== x) begin errs++; $display("FAIL drain%0d: got %h expected %h", k, d, x); end
    end
  endtask

  task automatic test_random();
    logic [31:0] d, x; logic e;
    for (int it = 0; it < 6; it++) begin
      int n = $urandom_range(8, 24);
      byte unsigned bb = 8'($urandom);
      bus_wr(4'h8, n, 4'hF);
      send(bb, n, 1); m_rx(bb);
      uart_rxd = 1; tick($urandom_range(0, 5));
      bus_rd(4'h4, d, e); x = m_status();
      checks++; if (d !== x) begin errs++; $display("FAIL rand_status%0d: got %h expected %h", it, d, x); end
      bus_rd(4'h0, d, e); x = m_data();
      checks++; if (d !== x) begin errs++; $display("FAIL rand_data%0d: n=%0d got %h expected %h", it, n, d, x); end
    end
    bus_wr(4'h8, 32'd8, 4'hF);
  endtask

  task automatic test_reset_midframe();
    logic [31:0] d, x; logic e;
    logic [7:0] c3 = 8'hC3;
    bus_wr(4'hC, 32'd1, 4'hF);
    send(8'h77, 8, 1); m_rx(8'h77);
    checks++; if (irq !== 1'b1) begin errs++; $display("FAIL pre_rst_irq: got %b expected 1", irq); end
    tcb_vld = 1; tcb_wen = 0; tcb_adr = 4'h4;
    uart_rxd = 0; tick(8);
    for (int i = 0; i < 4; i++) begin uart_rxd = c3[i]; tick(8); end
    #2 rst = 1;
    #1;
    checks++; if (irq !== 1'b0) begin errs++; $display("FAIL rst_irq: got %b expected 0", irq); end
    checks++; if (tcb_rdt !== 32'd0) begin errs++; $display("FAIL rst_rdt: got %h expected 0", tcb_rdt); end
    checks++; if (tcb_err !== 1'b0) begin errs++; $display("FAIL rst_err: got %b expected 0", tcb_err); end
    checks++; if (tcb_rdy !== 1'b1) begin errs++; $display("FAIL rst_rdy: got %b expected 1", tcb_rdy); end
    tcb_vld = 0; uart_rxd = 1;
    q.delete(); m_ovr = 0; m_fer = 0;
    tick(2); rst = 0; tick(2);
    bus_rd(4'h4, d, e); x = m_status();
    checks++; if (d !== x) begin errs++; $display("FAIL rst_status: got %h expected %h", d, x); end
    bus_rd(4'hC, d, e);
    checks++; if (d !== 32'd0) begin errs++; $display("FAIL rst_irqen: got %h expected 0", d); end
    bus_wr(4'h8, 32'd8, 4'hF);
    send(8'hC3, 8, 1); m_rx(8'hC3);
    bus_rd(4'h0, d, e); x = m_data();
    checks++; if (d !== x) begin errs++; $display("FAIL rst_after_data: got %h expected %h", d, x); end
  endtask

  initial begin
    tick(3);
    test_reset();
    test_basic();
    test_baud_reg();
    test_irq_overrun();
    test_framing();
    test_glitch();
    test_same_cycle();
    test_random();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
